// File: rtl/key_cond_pkg.sv
// Shared state type, 50 MHz timing defaults and counter sizing for the pushbutton conditioner.
// Purely declarative: no logic, no latency.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  localparam int         DEF_N_KEYS          = 4;
  localparam int         DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
  localparam int         DEF_REPEAT_DELAY    = 25000000;  // 0.5 s
  localparam int         DEF_REPEAT_PERIOD   = 5000000;   // 0.1 s
  localparam logic [3:0] DEF_REPEAT_MASK     = 4'b0011;   // next/prev repeat
  localparam int         DEF_CNT_BITS        = 25;

  // Smallest counter width able to hold the largest of the three timing values.
  function automatic int cnt_bits_for(input int debounce, input int delay, input int period);
    int m;
    m = debounce;
    if (delay > m) m = delay;
    if (period > m) m = period;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_conditioner_key_chan.sv
// One pushbutton: 2-flop sync, debounce, press/release pulses and typematic repeat ticks.
// Latency: raw edge to registered pulse is 1+DEBOUNCE_CYCLES edges; no backpressure, pulses are fire-and-forget.
module key_chan
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_BITS        = DEF_CNT_BITS,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam logic [CNT_BITS-1:0] DB_LAST     = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] DELAY_LAST  = CNT_BITS'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_BITS-1:0] PERIOD_LAST = CNT_BITS'(REPEAT_PERIOD - 1);

  logic                sync_q1;
  logic                sync_q2;
  logic [CNT_BITS-1:0] db_cnt;
  logic                key_low;
  logic                differs;
  logic                accept;
  logic                accept_press;
  logic                accept_release;

  rpt_state_t          state;
  rpt_state_t          state_nxt;
  logic [CNT_BITS-1:0] rcnt;
  logic [CNT_BITS-1:0] rcnt_nxt;
  logic                tick;

  assign key_low        = ~sync_q2;
  assign differs        = (key_low != pressed);
  assign accept         = differs && (db_cnt == DB_LAST);
  assign accept_press   = accept & ~pressed;
  assign accept_release = accept & pressed;

  // Synchroniser resets to "released" so a held key is re-accepted as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  // Any cycle that agrees with the accepted level restarts the stability window.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else if (!differs) begin
      db_cnt  <= '0;
    end else if (accept) begin
      db_cnt  <= '0;
      pressed <= ~pressed;
    end else begin
      db_cnt  <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    tick      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_press && REPEAT_EN) begin
          state_nxt = DELAY;
          rcnt_nxt  = '0;
        end
      end
      DELAY: begin
        if (rcnt == DELAY_LAST) begin
          tick      = 1'b1;
          state_nxt = REPEAT;
          rcnt_nxt  = '0;
        end else begin
          rcnt_nxt  = rcnt + 1'b1;
        end
      end
      REPEAT: begin
        if (rcnt == PERIOD_LAST) begin
          tick     = 1'b1;
          rcnt_nxt = '0;
        end else begin
          rcnt_nxt = rcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
      end
    endcase
    // Release wins over a coinciding tick so no step leaks out after letting go.
    if (accept_release) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
      tick      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      step_pulse    <= 1'b0;
    end else begin
      press_pulse   <= accept_press;
      release_pulse <= accept_release;
      step_pulse    <= accept_press | tick;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw active-low pushbuttons into clean levels, edge pulses and auto-repeat steps.
// Latency: 1+DEBOUNCE_CYCLES edges from raw edge to outputs; no backpressure, channels are independent.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int                N_KEYS          = DEF_N_KEYS,
  parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int                REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int                REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = N_KEYS'(DEF_REPEAT_MASK),
  parameter int                CNT_BITS        = DEF_CNT_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] step_pulse
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_DELAY < 0 ||
      CNT_BITS < cnt_bits_for(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_param_check
    $error("key_conditioner: timing parameters out of range for CNT_BITS");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_BITS       (CNT_BITS),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .step_pulse   (step_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed and random stimulus for key_conditioner, checked every cycle against a history-based model.
// The model derives acceptance from windows of raw samples and repeat ticks from press-relative arithmetic.
module tb_key_conditioner;

  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [3:0] MASK = 4'b0011;
  localparam int         MAXC = 4096;

  logic       clk;
  logic       reset;
  logic [3:0] key_n;
  logic [3:0] pressed;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] step_pulse;

  key_conditioner #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK),
    .CNT_BITS       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         n_vec;
  int         n_err;
  int         e;
  int         r_last;
  logic [3:0] raw_hist [0:MAXC-1];
  int         last_flip [4];
  int         last_press [4];
  logic [3:0] m_pressed;
  logic [3:0] rpt_on;
  logic [3:0] exp_press, exp_rel, exp_step;
  int         obs_press [4];
  int         obs_rel [4];
  int         obs_step [4];
  int         obs_press_edge [4];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, e, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, e, obs, expv);
    end
  endtask

  // Level seen by the debouncer at edge j: the raw sample from two edges earlier,
  // or "released" if that sample predates the end of reset.
  function automatic logic lvl(input int k, input int j);
    if (j - 2 <= r_last) return 1'b0;
    return ~raw_hist[j-2][k];
  endfunction

  task automatic model_edge(input logic [3:0] kn, input logic rst);
    logic flip;
    logic tk;
    raw_hist[e] = kn;
    exp_press = '0;
    exp_rel   = '0;
    exp_step  = '0;
    if (rst) begin
      r_last    = e;
      m_pressed = '0;
      rpt_on    = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        flip = (e - DB + 1 > last_flip[k]) && (e - DB + 1 > r_last);
        for (int j = e - DB + 1; j <= e; j++)
          if (flip && lvl(k, j) == m_pressed[k]) flip = 1'b0;
        tk = MASK[k] && rpt_on[k] && (e - last_press[k] >= RD) &&
             (((e - last_press[k] - RD) % RP) == 0);
        if (flip) begin
          if (m_pressed[k]) begin
            exp_rel[k] = 1'b1;
            tk         = 1'b0;
            rpt_on[k]  = 1'b0;
          end else begin
            exp_press[k]  = 1'b1;
            last_press[k] = e;
            rpt_on[k]     = 1'b1;
          end
          m_pressed[k] = ~m_pressed[k];
          last_flip[k] = e;
        end
        exp_step[k] = exp_press[k] | tk;
      end
    end
  endtask

  task automatic tick_edge(input logic [3:0] kn, input logic rst);
    @(negedge clk);
    key_n = kn;
    reset = rst;
    @(posedge clk);
    e++;
    if (e >= MAXC) begin
      $display("FAIL history_overflow edge %0d", e);
      $fatal(1, "cycle history exhausted");
    end
    model_edge(kn, rst);
    #1;
    chk("pressed", pressed, m_pressed);
    chk("press_pulse", press_pulse, exp_press);
    chk("release_pulse", release_pulse, exp_rel);
    chk("step_pulse", step_pulse, exp_step);
    for (int k = 0; k < 4; k++) begin
      if (press_pulse[k]) begin
        obs_press[k]++;
        obs_press_edge[k] = e;
      end
      if (release_pulse[k]) obs_rel[k]++;
      if (step_pulse[k]) obs_step[k]++;
    end
  endtask

  task automatic hold(input logic [3:0] kn, input int n);
    for (int i = 0; i < n; i++) tick_edge(kn, 1'b0);
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 4; k++) begin
      obs_press[k]      = 0;
      obs_rel[k]        = 0;
      obs_step[k]       = 0;
      obs_press_edge[k] = -1;
    end
  endtask

  initial begin
    int s;
    int rr;
    logic [3:0] kn;
    int len;
    logic rst;
    n_vec     = 0;
    n_err     = 0;
    e         = 0;
    r_last    = 0;
    m_pressed = '0;
    rpt_on    = '0;
    key_n     = 4'hF;
    reset     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      last_flip[k]  = -100;
      last_press[k] = -100;
    end
    clear_obs();

    // Reset with all keys released.
    for (int i = 0; i < 3; i++) tick_edge(4'hF, 1'b1);
    hold(4'hF, 5);

    // Clean press on key0, held 30 cycles, then released.
    clear_obs();
    s = e + 1;
    hold(4'b1110, 30);
    hold(4'hF, 15);
    chk_int("clean_press_edge", obs_press_edge[0], s + 5);
    chk_int("clean_press_count", obs_press[0], 1);
    chk_int("clean_step_count", obs_step[0], 8);
    chk_int("clean_release_count", obs_rel[0], 1);

    // Bouncing key1, then steady low.
    clear_obs();
    s = e + 1;
    for (int i = 0; i < 20; i++) hold(((i / 2) % 2 == 0) ? 4'b1101 : 4'b1111, 1);
    hold(4'b1101, 20);
    chk_int("bounce_press_count", obs_press[1], 1);
    chk_int("bounce_press_edge", obs_press_edge[1], s + 25);
    hold(4'hF, 10);

    // Masked key3 held 50 cycles.
    clear_obs();
    hold(4'b0111, 50);
    chk_int("masked_press_count", obs_press[3], 1);
    chk_int("masked_step_count", obs_step[3], 1);
    hold(4'hF, 10);

    // Keys 0 and 1 pressed together.
    clear_obs();
    s = e + 1;
    hold(4'b1100, 25);
    chk_int("dual_press_edge0", obs_press_edge[0], s + 5);
    chk_int("dual_press_edge1", obs_press_edge[1], s + 5);
    hold(4'hF, 10);

    // Reset while key0 is in REPEAT, key still held afterwards.
    hold(4'b1110, 20);
    for (int i = 0; i < 3; i++) tick_edge(4'b1110, 1'b1);
    rr = e;
    clear_obs();
    hold(4'b1110, 25);
    chk_int("post_reset_press_count", obs_press[0], 1);
    chk_int("post_reset_press_edge", obs_press_edge[0], rr + 6);
    hold(4'hF, 10);

    // Release accepted on the exact edge the first tick would fire.
    clear_obs();
    hold(4'b1110, 10);
    hold(4'hF, 8);
    chk_int("release_on_tick_steps", obs_step[0], 1);
    chk_int("release_on_tick_rel", obs_rel[0], 1);
    clear_obs();
    hold(4'b1110, 16);
    chk_int("repress_steps", obs_step[0], 2);
    hold(4'hF, 10);

    // Random segments, occasional reset.
    for (int seg = 0; seg < 60; seg++) begin
      kn  = 4'($urandom);
      len = int'($urandom_range(1, 25));
      rst = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < len; i++) tick_edge(kn, rst && (i < 2));
    end
    hold(4'hF, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Upstream input stage for the board's pushbuttons (KEY[3:0], active-low, bouncy, asynchronous to the clock).
- Per key: synchronises, debounces, and produces a clean level plus one-cycle event pulses.
- Provides typematic auto-repeat, so that holding "next"/"prev" steps the RAM address at a controlled rate.
- Its outputs drive the address/start logic of the Collatz display top level in place of raw KEY sampling and the ad-hoc hold counter.

Parameters:
N_KEYS, 4, number of independent key channels
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz)
REPEAT_DELAY, 25000000, cycles from accepted press to first auto-repeat pulse (0.5 s)
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (0.1 s)
REPEAT_MASK, 4'b0011, bit i = 1 enables auto-repeat on key i
CNT_BITS, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
clk  input  1  system clock (CLOCK_50)
reset  input  1  synchronous, active-high reset
key_n  input  N_KEYS  raw pushbuttons, active-low, asynchronous
pressed  output  N_KEYS  debounced level, 1 = held
press_pulse  output  N_KEYS  one-cycle pulse on accepted press
release_pulse  output  N_KEYS  one-cycle pulse on accepted release
step_pulse  output  N_KEYS  press_pulse OR auto-repeat tick; masked keys give press_pulse only

Behaviour:
- Reset, synchronous and active-high, applied at any time including mid-hold or mid-debounce:
  - synchroniser flops = 1 (released);
  - pressed = 0; all pulses = 0;
  - counters = 0; FSM = IDLE.
  - No pulse is emitted on reset entry or exit, even if a key is held; a held key is then seen as a fresh press after sync plus debounce.
- Synchroniser: 2 flops per key. A raw low sampled at edge t is visible as sync_low after edge t+1.
- Debounce, per key:
  - cnt increments each cycle that the synchronised level differs from pressed, and clears to 0 on any cycle it matches (any bounce restarts the window).
  - When cnt reaches DEBOUNCE_CYCLES-1 and still differs, pressed toggles on that edge and cnt clears.
  - Latency: a raw low first sampled at edge 0 gives pressed = 1 after edge 1+DEBOUNCE_CYCLES.
- Pulses:
  - press_pulse: high for exactly the cycle after pressed rises.
  - release_pulse: high for exactly the cycle after pressed falls.
  - Both are registered and never overlap on one key.
- Repeat FSM, per key (only when REPEAT_MASK[i] = 1):
  - IDLE -> DELAY on accepted press; rcnt = 0.
  - DELAY: rcnt counts up. At rcnt = REPEAT_DELAY-1, emit a tick, go to REPEAT, rcnt = 0.
  - REPEAT: at rcnt = REPEAT_PERIOD-1, emit a tick, rcnt = 0.
  - Any state -> IDLE on accepted release, same edge, with no tick on that cycle.
  - First tick: REPEAT_DELAY cycles after press_pulse. Subsequent ticks: every REPEAT_PERIOD cycles.
- step_pulse = press_pulse | tick, registered-equivalent timing: same cycle as press_pulse or tick.
- Channels are fully independent. Simultaneous presses on several keys each produce their own pulses in the same cycle; there is no priority resolution here (the consumer decides, e.g. next wins over prev).
- Counter widths: saturation never occurs given the CNT_BITS constraint. An elaboration-time assertion checks the parameter bounds; DEBOUNCE_CYCLES and REPEAT_PERIOD must be >= 1.

Decomposition:
- Package key_cond_pkg:
  - enum rpt_state_t {IDLE, DELAY, REPEAT};
  - default timing constants at 50 MHz;
  - a function computing the required CNT_BITS.
- Sub-module key_chan: one key's synchroniser, debounce counter, repeat FSM and pulse flops.
- key_conditioner: a generate loop of N_KEYS key_chan instances, passing REPEAT_MASK[i] as a per-instance parameter.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; raw low first sampled at edge 0):
- Clean press held, key0: pressed=1 after edge 5; press_pulse and step_pulse high in cycle 5→6 only; step ticks at cycles 15, 18, 21...; release gives pressed=0 four-plus-two cycles later, with one release_pulse and no further step.
- Bounce, key1 toggling low/high every 2 cycles for 20 cycles, then steady low: no pulse during bouncing; exactly one press_pulse, 6 cycles after the last transition.
- Masked key3 held 50 cycles: exactly one step_pulse and one press_pulse; no repeats.
- Keys 0 and 1 pressed on the same edge: both press_pulse bits set in the same cycle; repeat ticks coincide.
- Reset asserted during the REPEAT state with key0 held, deasserted 3 cycles later: all outputs 0 during and after reset; pressed re-rises after sync plus debounce with a single new press_pulse; repeat timing restarts from DELAY.
- Release at the exact cycle a repeat tick would fire: no tick emitted; FSM in IDLE; a subsequent press restarts DELAY from 0.
